// File: rtl/mmu_axi_arbiter_if.sv
// Bus bundle between the cache clients, the arbiter and the MMU-side AXI
// request channel.
//   master : arbiter view (takes client requests and downstream responses,
//            drives completions and downstream requests)
//   slave  : environment view (clients plus downstream channel)
// Client-side vectors are NUM_REQ wide; client i's 32-bit fields sit at
// [32*i +: 32].
interface mmu_axi_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]    req_rd_rq;
   logic [32*NUM_REQ-1:0] req_rd_addr;
   logic [31:0]           req_rd_data;
   logic [NUM_REQ-1:0]    req_rd_valid;
   logic [NUM_REQ-1:0]    req_wr_rq;
   logic [32*NUM_REQ-1:0] req_wr_addr;
   logic [32*NUM_REQ-1:0] req_wr_data;
   logic [NUM_REQ-1:0]    req_wr_done;
   logic [NUM_REQ-1:0]    req_err;

   logic                  axi_rd_rq;
   logic [31:0]           axi_rd_addr;
   logic [31:0]           axi_rd_data;
   logic                  axi_rd_valid;
   logic                  axi_rd_valid_ack;
   logic                  axi_wr_rq;
   logic                  axi_wr_rq_ack;
   logic [31:0]           axi_wr_addr;
   logic [31:0]           axi_wr_data;
   logic                  axi_wr_done;
   logic                  axi_wr_done_ack;
   logic [IDW-1:0]        axi_id;

   modport master (
      input  req_rd_rq, req_rd_addr, req_wr_rq, req_wr_addr, req_wr_data,
      input  axi_rd_data, axi_rd_valid, axi_wr_rq_ack, axi_wr_done,
      output req_rd_data, req_rd_valid, req_wr_done, req_err,
      output axi_rd_rq, axi_rd_addr, axi_rd_valid_ack,
      output axi_wr_rq, axi_wr_addr, axi_wr_data, axi_wr_done_ack, axi_id
   );

   modport slave (
      output req_rd_rq, req_rd_addr, req_wr_rq, req_wr_addr, req_wr_data,
      output axi_rd_data, axi_rd_valid, axi_wr_rq_ack, axi_wr_done,
      input  req_rd_data, req_rd_valid, req_wr_done, req_err,
      input  axi_rd_rq, axi_rd_addr, axi_rd_valid_ack,
      input  axi_wr_rq, axi_wr_addr, axi_wr_data, axi_wr_done_ack, axi_id
   );
endinterface

// File: rtl/mmu_axi_arbiter.sv
// Shares the MMU-side AXI request channel between NUM_REQ cache clients
// (I-cache = 0, D-cache = 1). Round-robin grant, one transaction in flight,
// write before read within a client, 4-phase rq/valid/ack handshakes and a
// per-phase watchdog that aborts a stalled transaction with req_err.
// Ports:
//   mmu_clk : sole clock, rising edge
//   i_rstn  : asynchronous active-low reset
//   bus     : mmu_axi_arbiter_if.master (client requests/completions and
//             downstream AXI request channel)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; round-robin scan of pending clients
// RD_REQ  | axi_rd_rq high, waiting for axi_rd_valid
// RD_ACK  | axi_rd_valid_ack high, waiting for axi_rd_valid to drop
// WR_REQ  | axi_wr_rq high, waiting for axi_wr_rq_ack
// WR_WAIT | write accepted, waiting for axi_wr_done
// WR_ACK  | axi_wr_done_ack high, waiting for axi_wr_done to drop
module mmu_axi_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                   mmu_clk,
   input  logic                   i_rstn,
   mmu_axi_arbiter_if.master      bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam bit WD_EN = (TIMEOUT_CYC > 0);
   // Loaded on entry to a watched phase; abort fires when it has counted
   // down to zero, i.e. after exactly TIMEOUT_CYC cycles in that phase.
   localparam logic [WDW-1:0] WD_LOAD = (TIMEOUT_CYC > 0) ? WDW'(TIMEOUT_CYC - 1) : '0;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_ACK, WR_REQ, WR_WAIT, WR_ACK} state_t;

   state_t             state_q;
   logic [IDW-1:0]     rr_q, rr_d;
   logic [IDW-1:0]     g_q, g_d;
   logic               found_d;
   logic [NUM_REQ-1:0] pending;
   logic [WDW-1:0]     wd_q;
   logic               abort_d;
   int                 idx;

   logic [31:0]        rd_data_q;
   logic [NUM_REQ-1:0] rd_valid_q, wr_done_q, err_q;
   logic               rd_rq_q, rd_ack_q, wr_rq_q, done_ack_q;
   logic [31:0]        rd_addr_q, wr_addr_q, wr_data_q;
   logic [IDW-1:0]     id_q;

   assign pending = bus.req_wr_rq | bus.req_rd_rq;

   always_comb begin
      found_d = 1'b0;
      g_d     = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_q) + k) % NUM_REQ;
         if (!found_d && pending[idx]) begin
            found_d = 1'b1;
            g_d     = IDW'(idx);
         end
      end
      rr_d = (int'(g_d) == NUM_REQ - 1) ? '0 : g_d + IDW'(1);
   end

   // Completion is tested in the abort term so it wins a same-cycle race.
   always_comb begin
      abort_d = 1'b0;
      if (WD_EN && wd_q == '0) begin
         case (state_q)
            RD_REQ:  abort_d = !bus.axi_rd_valid;
            WR_REQ:  abort_d = !bus.axi_wr_rq_ack;
            WR_WAIT: abort_d = !bus.axi_wr_done;
            default: abort_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge mmu_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         g_q        <= '0;
         wd_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         wr_done_q  <= '0;
         err_q      <= '0;
         rd_rq_q    <= 1'b0;
         rd_ack_q   <= 1'b0;
         wr_rq_q    <= 1'b0;
         done_ack_q <= 1'b0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         id_q       <= '0;
      end else begin
         rd_valid_q <= '0;
         wr_done_q  <= '0;
         err_q      <= '0;
         if (abort_d) begin
            rd_rq_q    <= 1'b0;
            wr_rq_q    <= 1'b0;
            rd_ack_q   <= 1'b0;
            done_ack_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            id_q       <= '0;
            err_q[g_q] <= 1'b1;
            state_q    <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (found_d) begin
                     g_q       <= g_d;
                     id_q      <= g_d;
                     rr_q      <= rr_d;
                     wd_q      <= WD_LOAD;
                     rd_addr_q <= {bus.req_rd_addr[int'(g_d)*32 + 2 +: 30], 2'b00};
                     wr_addr_q <= {bus.req_wr_addr[int'(g_d)*32 + 2 +: 30], 2'b00};
                     wr_data_q <= bus.req_wr_data[int'(g_d)*32 +: 32];
                     if (bus.req_wr_rq[g_d]) begin
                        wr_rq_q <= 1'b1;
                        state_q <= WR_REQ;
                     end else begin
                        rd_rq_q <= 1'b1;
                        state_q <= RD_REQ;
                     end
                  end
               end
               RD_REQ: begin
                  if (bus.axi_rd_valid) begin
                     rd_rq_q         <= 1'b0;
                     rd_data_q       <= bus.axi_rd_data;
                     rd_valid_q[g_q] <= 1'b1;
                     rd_ack_q        <= 1'b1;
                     state_q         <= RD_ACK;
                  end else begin
                     wd_q <= wd_q - WDW'(1);
                  end
               end
               RD_ACK: begin
                  if (!bus.axi_rd_valid) begin
                     rd_ack_q <= 1'b0;
                     state_q  <= IDLE;
                  end
               end
               WR_REQ: begin
                  if (bus.axi_wr_rq_ack) begin
                     wr_rq_q <= 1'b0;
                     wd_q    <= WD_LOAD;
                     state_q <= WR_WAIT;
                  end else begin
                     wd_q <= wd_q - WDW'(1);
                  end
               end
               WR_WAIT: begin
                  if (bus.axi_wr_done) begin
                     wr_done_q[g_q] <= 1'b1;
                     done_ack_q     <= 1'b1;
                     state_q        <= WR_ACK;
                  end else begin
                     wd_q <= wd_q - WDW'(1);
                  end
               end
               WR_ACK: begin
                  if (!bus.axi_wr_done) begin
                     done_ack_q <= 1'b0;
                     state_q    <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.req_rd_data      = rd_data_q;
   assign bus.req_rd_valid     = rd_valid_q;
   assign bus.req_wr_done      = wr_done_q;
   assign bus.req_err          = err_q;
   assign bus.axi_rd_rq        = rd_rq_q;
   assign bus.axi_rd_addr      = rd_addr_q;
   assign bus.axi_rd_valid_ack = rd_ack_q;
   assign bus.axi_wr_rq        = wr_rq_q;
   assign bus.axi_wr_addr      = wr_addr_q;
   assign bus.axi_wr_data      = wr_data_q;
   assign bus.axi_wr_done_ack  = done_ack_q;
   assign bus.axi_id           = id_q;
endmodule

// File: tb/tb_mmu_axi_arbiter.sv
module tb_mmu_axi_arbiter;
   logic mmu_clk = 1'b0;
   logic i_rstn  = 1'b0;
   always #5 mmu_clk = ~mmu_clk;

   mmu_axi_arbiter_if #(.NUM_REQ(2)) bus();
   mmu_axi_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(8)) dut (
      .mmu_clk(mmu_clk),
      .i_rstn (i_rstn),
      .bus    (bus)
   );

   // kind: 0 read complete, 1 write done, 2 watchdog error
   typedef struct {
      int          kind;
      int          client;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic        is_wr;
      int          client;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_addr;
      int          hold;
   } vec_t;

   exp_t sb[$];
   exp_t e;
   vec_t vecs[5];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge mmu_clk);
   endtask

   function automatic logic [11:0] out_flags();
      return {|bus.req_rd_data, |bus.req_rd_valid, |bus.req_wr_done, |bus.req_err,
              bus.axi_rd_rq, |bus.axi_rd_addr, bus.axi_rd_valid_ack, bus.axi_wr_rq,
              |bus.axi_wr_addr, |bus.axi_wr_data, bus.axi_wr_done_ack, |bus.axi_id};
   endfunction

   // Completion monitor: every pulse must match the head of the scoreboard.
   always @(negedge mmu_clk) begin
      if (i_rstn && (|{bus.req_rd_valid, bus.req_wr_done, bus.req_err})) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: rd_valid=%b wr_done=%b err=%b, expected no pulse",
                     bus.req_rd_valid, bus.req_wr_done, bus.req_err);
         end else begin
            e = sb.pop_front();
            chk("sb_rd_valid", 64'(bus.req_rd_valid), (e.kind == 0) ? 64'(2'b01 << e.client) : 64'(0));
            chk("sb_wr_done",  64'(bus.req_wr_done),  (e.kind == 1) ? 64'(2'b01 << e.client) : 64'(0));
            chk("sb_err",      64'(bus.req_err),      (e.kind == 2) ? 64'(2'b01 << e.client) : 64'(0));
            if (e.kind == 0) chk("sb_rd_data", 64'(bus.req_rd_data), 64'(e.data));
         end
      end
   end

   task automatic wait_req(input logic is_wr, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!(is_wr ? bus.axi_wr_rq : bus.axi_rd_rq) && cyc < 20);
   endtask

   task automatic do_reset();
      i_rstn = 1'b0;
      bus.req_rd_rq = '0;  bus.req_wr_rq = '0;
      bus.req_rd_addr = '0; bus.req_wr_addr = '0; bus.req_wr_data = '0;
      bus.axi_rd_data = '0; bus.axi_rd_valid = 1'b0;
      bus.axi_wr_rq_ack = 1'b0; bus.axi_wr_done = 1'b0;
      tick(2);
      #2 i_rstn = 1'b1;
      tick();
   endtask

   task automatic run_read(input int c, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input int hold);
      int cyc;
      bus.req_rd_addr[32*c +: 32] = addr;
      bus.req_rd_rq[c] = 1'b1;
      sb.push_back('{kind: 0, client: c, data: rdata});
      wait_req(1'b0, cyc);
      chk("rd_grant_latency", 64'(cyc), 64'(1));
      chk("rd_axi_id", 64'(bus.axi_id), 64'(c));
      chk("rd_axi_addr", 64'(bus.axi_rd_addr), 64'(exp_addr));
      bus.axi_rd_data  = rdata;
      bus.axi_rd_valid = 1'b1;
      tick();
      chk("rd_ack_set", 64'(bus.axi_rd_valid_ack), 64'(1));
      chk("rd_rq_dropped", 64'(bus.axi_rd_rq), 64'(0));
      bus.req_rd_rq[c] = 1'b0;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("rd_ack_held", 64'(bus.axi_rd_valid_ack), 64'(1));
      end
      bus.axi_rd_valid = 1'b0;
      bus.axi_rd_data  = '0;
      tick();
      chk("rd_ack_clear", 64'(bus.axi_rd_valid_ack), 64'(0));
   endtask

   task automatic run_write(input int c, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_addr);
      int cyc;
      bus.req_wr_addr[32*c +: 32] = addr;
      bus.req_wr_data[32*c +: 32] = wdata;
      bus.req_wr_rq[c] = 1'b1;
      sb.push_back('{kind: 1, client: c, data: 32'h0});
      wait_req(1'b1, cyc);
      chk("wr_grant_latency", 64'(cyc), 64'(1));
      chk("wr_axi_id", 64'(bus.axi_id), 64'(c));
      chk("wr_axi_addr", 64'(bus.axi_wr_addr), 64'(exp_addr));
      chk("wr_axi_data", 64'(bus.axi_wr_data), 64'(wdata));
      chk("wr_no_rd_rq", 64'(bus.axi_rd_rq), 64'(0));
      tick(2);
      chk("wr_rq_held", 64'(bus.axi_wr_rq), 64'(1));
      bus.axi_wr_rq_ack = 1'b1;
      tick();
      chk("wr_rq_dropped", 64'(bus.axi_wr_rq), 64'(0));
      bus.axi_wr_rq_ack = 1'b0;
      tick();
      bus.axi_wr_done = 1'b1;
      tick();
      chk("wr_done_ack_set", 64'(bus.axi_wr_done_ack), 64'(1));
      bus.req_wr_rq[c] = 1'b0;
      bus.axi_wr_done  = 1'b0;
      tick();
      chk("wr_done_ack_clear", 64'(bus.axi_wr_done_ack), 64'(0));
   endtask

   // Both clients hold rd_rq; grants must alternate starting at client 0.
   task automatic run_rr(input int n);
      int cyc;
      bus.req_rd_addr[31:0]  = 32'h0000_0103;
      bus.req_rd_addr[63:32] = 32'h0000_0206;
      for (int k = 0; k < n; k++)
         sb.push_back('{kind: 0, client: k % 2, data: 32'h1111_0000 + 32'(k)});
      bus.req_rd_rq = 2'b11;
      for (int k = 0; k < n; k++) begin
         wait_req(1'b0, cyc);
         chk("rr_grant_seen", 64'(bus.axi_rd_rq), 64'(1));
         chk("rr_axi_id", 64'(bus.axi_id), 64'(k % 2));
         chk("rr_axi_addr", 64'(bus.axi_rd_addr), (k % 2 == 1) ? 64'(32'h204) : 64'(32'h100));
         bus.axi_rd_data  = 32'h1111_0000 + 32'(k);
         bus.axi_rd_valid = 1'b1;
         tick();
         if (k == n - 1) bus.req_rd_rq = 2'b00;
         bus.axi_rd_valid = 1'b0;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int cyc;
      int n;

      vecs[0] = '{is_wr: 1'b0, client: 1, addr: 32'h1000_0007, data: 32'hDEAD_BEEF, exp_addr: 32'h1000_0004, hold: 0};
      vecs[1] = '{is_wr: 1'b0, client: 0, addr: 32'h0000_0ABC, data: 32'h1234_5678, exp_addr: 32'h0000_0ABC, hold: 0};
      vecs[2] = '{is_wr: 1'b1, client: 0, addr: 32'h2000_0003, data: 32'hCAFE_F00D, exp_addr: 32'h2000_0000, hold: 0};
      vecs[3] = '{is_wr: 1'b1, client: 1, addr: 32'hFFFF_FFFF, data: 32'hA5A5_5A5A, exp_addr: 32'hFFFF_FFFC, hold: 0};
      vecs[4] = '{is_wr: 1'b0, client: 1, addr: 32'h8000_0002, data: 32'h0BAD_F00D, exp_addr: 32'h8000_0000, hold: 5};

      i_rstn = 1'b0;
      bus.req_rd_rq = '0;  bus.req_wr_rq = '0;
      bus.req_rd_addr = '0; bus.req_wr_addr = '0; bus.req_wr_data = '0;
      bus.axi_rd_data = '0; bus.axi_rd_valid = 1'b0;
      bus.axi_wr_rq_ack = 1'b0; bus.axi_wr_done = 1'b0;
      tick(2);
      chk("reset_outputs", 64'(out_flags()), 64'(0));
      #2 i_rstn = 1'b1;
      tick();

      // Single transactions, including the held-valid read.
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].is_wr)
            run_write(vecs[i].client, vecs[i].addr, vecs[i].data, vecs[i].exp_addr);
         else
            run_read(vecs[i].client, vecs[i].addr, vecs[i].data, vecs[i].exp_addr, vecs[i].hold);
      end

      // Write before read within client 0.
      bus.req_rd_addr[31:0] = 32'h4000_0010;
      bus.req_rd_rq[0] = 1'b1;
      run_write(0, 32'h4000_0020, 32'h0000_00FF, 32'h4000_0020);
      run_read(0, 32'h4000_0010, 32'h7777_0000, 32'h4000_0010, 0);

      // Watchdog: read that never gets valid.
      bus.req_rd_addr[63:32] = 32'h5000_0000;
      bus.req_rd_rq[1] = 1'b1;
      sb.push_back('{kind: 2, client: 1, data: 32'h0});
      wait_req(1'b0, cyc);
      n = bus.axi_rd_rq ? 1 : 0;
      while (bus.axi_rd_rq && n < 20) begin
         tick();
         if (bus.axi_rd_rq) n++;
      end
      bus.req_rd_rq[1] = 1'b0;
      chk("wd_cycles_in_rd_req", 64'(n), 64'(8));
      chk("wd_rd_rq_dropped", 64'(bus.axi_rd_rq), 64'(0));
      chk("wd_axi_id_cleared", 64'(bus.axi_id), 64'(0));
      tick(2);
      run_read(1, 32'h5000_0004, 32'h0000_1234, 32'h5000_0004, 0);

      // Round robin from a fresh reset.
      do_reset();
      run_rr(4);

      // Reset in WR_WAIT, then client 0 must win first again.
      bus.req_wr_addr[31:0] = 32'h3000_0008;
      bus.req_wr_data[31:0] = 32'h0000_1234;
      bus.req_wr_rq[0] = 1'b1;
      wait_req(1'b1, cyc);
      chk("rst_wr_grant", 64'(bus.axi_wr_rq), 64'(1));
      bus.axi_wr_rq_ack = 1'b1;
      tick();
      bus.axi_wr_rq_ack = 1'b0;
      bus.axi_wr_done   = 1'b1;
      #2 i_rstn = 1'b0;
      #1 chk("async_reset_outputs", 64'(out_flags()), 64'(0));
      tick();
      bus.axi_wr_done = 1'b0;
      bus.req_wr_rq   = '0;
      tick();
      chk("reset_held_outputs", 64'(out_flags()), 64'(0));
      #2 i_rstn = 1'b1;
      tick();
      run_rr(2);

      tick(3);
      chk("sb_empty_at_end", 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
